// File: rtl/hub75_rx.sv
// HUB75 receiver: synchronises the panel bus, rebuilds each latched bit-plane row and streams it out one column per beat.
// Define HUB75_RX_OE_MEASURE_EN to add the OE on-time counter (o_oe_cycles / o_oe_valid).
module hub75_rx #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  parameter int row_wd_p   = $clog2(vpixel_p / segments_p)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_sclk,
  input  logic                        i_stb,
  input  logic                        i_oe,
  input  logic [4:0]                  i_row_sel,
  input  logic [segments_p-1:0]       i_r,
  input  logic [segments_p-1:0]       i_g,
  input  logic [segments_p-1:0]       i_b,
  output logic                        o_wr_valid,
  input  logic                        i_wr_ready,
  output logic [row_wd_p-1:0]         o_wr_row,
  output logic [$clog2(hpixel_p)-1:0] o_wr_col,
  output logic [$clog2(bpp_p)-1:0]    o_wr_plane,
  output logic [3*segments_p-1:0]     o_wr_data,
  output logic                        o_col_err,
  output logic                        o_overrun
`ifdef HUB75_RX_OE_MEASURE_EN
  ,
  output logic [31:0]                 o_oe_cycles,
  output logic                        o_oe_valid
`endif
);

  localparam int col_wd_l   = $clog2(hpixel_p);
  localparam int cnt_wd_l   = $clog2(hpixel_p + 1);
  localparam int plane_wd_l = $clog2(bpp_p);
  localparam int dw_l       = 3 * segments_p;
  localparam int sw_l       = dw_l + 8;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } state_t;

  logic [dw_l-1:0] rgb_pin;
  logic [sw_l-1:0] pin_vec;
  logic [sw_l-1:0] sync1_reg;
  logic [sw_l-1:0] sync2_reg;

  generate
    for (genvar gi = 0; gi < segments_p; gi++) begin : g_pack
      assign rgb_pin[3*gi+2] = i_r[gi];
      assign rgb_pin[3*gi+1] = i_g[gi];
      assign rgb_pin[3*gi]   = i_b[gi];
    end
  endgenerate

  // Every pin shares one synchroniser so data stays aligned with sclk/stb.
  assign pin_vec = {i_sclk, i_stb, i_oe, i_row_sel, rgb_pin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pin_vec;
      sync2_reg <= sync1_reg;
    end
  end

  logic            sclk_prev_reg;
  logic            stb_prev_reg;
  logic            sclk_rise_reg;
  logic            stb_rise_reg;
  logic [4:0]      row_d_reg;
  logic [dw_l-1:0] rgb_d_reg;

  // Registered edge detect; row and RGB are delayed by the same stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_reg <= 1'b0;
      stb_prev_reg  <= 1'b0;
      sclk_rise_reg <= 1'b0;
      stb_rise_reg  <= 1'b0;
      row_d_reg     <= '0;
      rgb_d_reg     <= '0;
    end else begin
      sclk_prev_reg <= sync2_reg[sw_l-1];
      sclk_rise_reg <= sync2_reg[sw_l-1] & ~sclk_prev_reg;
      stb_prev_reg  <= sync2_reg[sw_l-2];
      stb_rise_reg  <= sync2_reg[sw_l-2] & ~stb_prev_reg;
      row_d_reg     <= sync2_reg[dw_l+4:dw_l];
      rgb_d_reg     <= sync2_reg[dw_l-1:0];
    end
  end

  state_t                state_reg;
  logic [cnt_wd_l-1:0]   col_cnt_reg;
  logic [cnt_wd_l-1:0]   col_cnt_next;
  logic                  col_ovf_reg;
  logic                  col_ovf_next;
  logic                  col_full;
  logic                  sclk_go;
  logic                  latch_go;
  logic [dw_l-1:0]       shift_reg  [hpixel_p];
  logic [dw_l-1:0]       shift_next [hpixel_p];
  logic [dw_l-1:0]       hold_reg   [hpixel_p];

  assign col_full     = (col_cnt_reg == cnt_wd_l'(hpixel_p));
  assign sclk_go      = i_enable & sclk_rise_reg & ~col_full;
  assign latch_go     = i_enable & stb_rise_reg;
  assign col_cnt_next = col_cnt_reg + cnt_wd_l'(sclk_go);
  // The count saturates, so overlong rows are remembered separately for o_col_err.
  assign col_ovf_next = col_ovf_reg | (i_enable & sclk_rise_reg & col_full);

  generate
    for (genvar gi = 0; gi < hpixel_p; gi++) begin : g_shift
      assign shift_next[gi] = (sclk_go && col_cnt_reg == cnt_wd_l'(gi)) ? rgb_d_reg : shift_reg[gi];
    end
  endgenerate

  // The shift chain restarts empty after every latch so short rows read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < hpixel_p; i++) begin
        shift_reg[i] <= '0;
        hold_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < hpixel_p; i++) begin
        shift_reg[i] <= latch_go ? '0 : shift_next[i];
        if (latch_go && state_reg == ST_IDLE) begin
          hold_reg[i] <= shift_next[i];
        end
      end
    end
  end

  logic [row_wd_p-1:0]   row_in;
  logic [row_wd_p-1:0]   last_row_reg;
  logic [plane_wd_l-1:0] plane_cnt_reg;
  logic [plane_wd_l-1:0] plane_sel;
  logic [plane_wd_l-1:0] plane_inc;
  logic [col_wd_l-1:0]   col_inc;

  logic                  valid_reg;
  logic [row_wd_p-1:0]   row_reg;
  logic [col_wd_l-1:0]   col_reg;
  logic [plane_wd_l-1:0] plane_reg;
  logic [dw_l-1:0]       data_reg;
  logic                  col_err_reg;
  logic                  overrun_reg;

  assign row_in    = row_d_reg[row_wd_p-1:0];
  assign plane_sel = (row_in == last_row_reg) ? plane_cnt_reg : '0;
  assign plane_inc = (plane_sel == plane_wd_l'(bpp_p - 1)) ? '0 : plane_sel + 1'b1;
  assign col_inc   = col_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      col_cnt_reg   <= '0;
      col_ovf_reg   <= 1'b0;
      last_row_reg  <= '0;
      plane_cnt_reg <= '0;
      valid_reg     <= 1'b0;
      row_reg       <= '0;
      col_reg       <= '0;
      plane_reg     <= '0;
      data_reg      <= '0;
      col_err_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      col_err_reg <= 1'b0;
      overrun_reg <= 1'b0;
      if (!i_enable) begin
        state_reg     <= ST_IDLE;
        valid_reg     <= 1'b0;
        col_cnt_reg   <= '0;
        col_ovf_reg   <= 1'b0;
        plane_cnt_reg <= '0;
      end else begin
        col_cnt_reg <= latch_go ? '0 : col_cnt_next;
        col_ovf_reg <= latch_go ? 1'b0 : col_ovf_next;
        case (state_reg)
          ST_IDLE: begin
            if (latch_go) begin
              row_reg       <= row_in;
              plane_reg     <= plane_sel;
              last_row_reg  <= row_in;
              plane_cnt_reg <= plane_inc;
              col_err_reg   <= (col_cnt_next != cnt_wd_l'(hpixel_p)) | col_ovf_next;
              col_reg       <= '0;
              data_reg      <= shift_next[0];
              valid_reg     <= 1'b1;
              state_reg     <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (latch_go) begin
              overrun_reg <= 1'b1;
            end
            if (i_wr_ready) begin
              if (col_reg == col_wd_l'(hpixel_p - 1)) begin
                valid_reg <= 1'b0;
                state_reg <= ST_IDLE;
              end else begin
                col_reg  <= col_inc;
                data_reg <= hold_reg[col_inc];
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_wr_valid = valid_reg;
  assign o_wr_row   = row_reg;
  assign o_wr_col   = col_reg;
  assign o_wr_plane = plane_reg;
  assign o_wr_data  = data_reg;
  assign o_col_err  = col_err_reg;
  assign o_overrun  = overrun_reg;

`ifdef HUB75_RX_OE_MEASURE_EN
  logic        oe_low_reg;
  logic [31:0] oe_cnt_reg;
  logic [31:0] oe_cycles_reg;
  logic        oe_valid_reg;

  // The cycle carrying the stb rise starts the next interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_low_reg    <= 1'b0;
      oe_cnt_reg    <= '0;
      oe_cycles_reg <= '0;
      oe_valid_reg  <= 1'b0;
    end else begin
      oe_low_reg   <= ~sync2_reg[sw_l-3];
      oe_valid_reg <= 1'b0;
      if (stb_rise_reg) begin
        oe_cycles_reg <= oe_cnt_reg;
        oe_valid_reg  <= 1'b1;
        oe_cnt_reg    <= {31'd0, oe_low_reg};
      end else if (oe_low_reg && oe_cnt_reg != '1) begin
        oe_cnt_reg <= oe_cnt_reg + 1'b1;
      end
    end
  end

  assign o_oe_cycles = oe_cycles_reg;
  assign o_oe_valid  = oe_valid_reg;
`else
  logic unused_oe;
  assign unused_oe = sync2_reg[sw_l-3];
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Scoreboard bench for hub75_rx: drives HUB75 rows and latches, checks every drained beat against queued expectations.
module tb_hub75_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_sclk = 1'b0;
  logic       i_stb = 1'b0;
  logic       i_oe = 1'b1;
  logic [4:0] i_row_sel = '0;
  logic [1:0] i_r = '0;
  logic [1:0] i_g = '0;
  logic [1:0] i_b = '0;
  logic       i_wr_ready = 1'b1;
  logic       o_wr_valid;
  logic [4:0] o_wr_row;
  logic [5:0] o_wr_col;
  logic [2:0] o_wr_plane;
  logic [5:0] o_wr_data;
  logic       o_col_err;
  logic       o_overrun;
`ifdef HUB75_RX_OE_MEASURE_EN
  logic [31:0] o_oe_cycles;
  logic        o_oe_valid;
`endif

  int checks = 0;
  int errors = 0;
  int col_err_seen = 0;
  int overrun_seen = 0;

  typedef struct packed {
    logic [4:0] row;
    logic [5:0] col;
    logic [2:0] plane;
    logic [5:0] data;
  } beat_t;

  beat_t      sb[$];
  beat_t      mon_got;
  beat_t      mon_exp;
  logic [5:0] row_data [64];

  hub75_rx dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_sclk     (i_sclk),
    .i_stb      (i_stb),
    .i_oe       (i_oe),
    .i_row_sel  (i_row_sel),
    .i_r        (i_r),
    .i_g        (i_g),
    .i_b        (i_b),
    .o_wr_valid (o_wr_valid),
    .i_wr_ready (i_wr_ready),
    .o_wr_row   (o_wr_row),
    .o_wr_col   (o_wr_col),
    .o_wr_plane (o_wr_plane),
    .o_wr_data  (o_wr_data),
    .o_col_err  (o_col_err),
    .o_overrun  (o_overrun)
`ifdef HUB75_RX_OE_MEASURE_EN
    ,
    .o_oe_cycles(o_oe_cycles),
    .o_oe_valid (o_oe_valid)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_col_err) col_err_seen++;
    if (o_overrun) overrun_seen++;
    if (!rst && o_wr_valid && i_wr_ready) begin
      mon_got = {o_wr_row, o_wr_col, o_wr_plane, o_wr_data};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got row %0d col %0d plane %0d data %02h, required no beat",
                 o_wr_row, o_wr_col, o_wr_plane, o_wr_data);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL beat: got row %0d col %0d plane %0d data %02h, required row %0d col %0d plane %0d data %02h",
                   mon_got.row, mon_got.col, mon_got.plane, mon_got.data,
                   mon_exp.row, mon_exp.col, mon_exp.plane, mon_exp.data);
        end else begin
          $display("beat row %0d col %0d plane %0d data %02h", o_wr_row, o_wr_col, o_wr_plane, o_wr_data);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_col(input logic [5:0] v);
    i_r = {v[5], v[2]};
    i_g = {v[4], v[1]};
    i_b = {v[3], v[0]};
    tick(3);
    i_sclk = 1'b1;
    tick(3);
    i_sclk = 1'b0;
  endtask

  task automatic shift_row(input int n);
    for (int k = 0; k < n; k++) send_col(row_data[k % 64]);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) row_data[k] = 6'($urandom);
  endtask

  task automatic push_beats(input logic [4:0] row, input logic [2:0] plane, input int n, input int ncols);
    logic [5:0] d;
    for (int c = 0; c < n; c++) begin
      d = (c < ncols) ? row_data[c] : 6'd0;
      sb.push_back({row, 6'(c), plane, d});
    end
  endtask

  // lat = posedges from the stb pin rise to the first visible o_wr_valid (0 if none within 6).
  task automatic latch(input logic [4:0] row, output int lat);
    i_row_sel = row;
    tick(3);
    i_stb = 1'b1;
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      if (o_wr_valid && lat == 0) lat = n;
    end
    i_stb = 1'b0;
    tick(3);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || o_wr_valid) && n < 2000) begin
      tick(1);
      n++;
    end
    checks++;
    if (sb.size() != 0 || o_wr_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, valid %0b, required 0 and 0", name, sb.size(), o_wr_valid);
      sb.delete();
    end
  endtask

  task automatic wait_col(input logic [5:0] col, input string name);
    int n = 0;
    while (!(o_wr_valid && o_wr_col == col) && n < 500) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(o_wr_valid && o_wr_col == col)) begin
      errors++;
      $display("FAIL %s_reach_col: got valid %0b col %0d, required valid 1 col %0d", name, o_wr_valid, o_wr_col, col);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data, o_col_err, o_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %0b row %0d col %0d plane %0d data %02h, required all 0",
               o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data);
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if ({o_wr_valid, o_col_err, o_overrun} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: got valid %0b col_err %0b overrun %0b, required 0", o_wr_valid, o_col_err, o_overrun);
    end
  endtask

  task automatic test_single_plane();
    int lat;
    int ce0;
    for (int k = 0; k < 64; k++) row_data[k] = 6'(k);
    shift_row(64);
    ce0 = col_err_seen;
    push_beats(5'd5, 3'd0, 64, 64);
    latch(5'd5, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL stb_latency: got %0d clk, required 4", lat);
    end
    wait_idle("single_plane");
    checks++;
    if (col_err_seen !== ce0) begin
      errors++;
      $display("FAIL single_plane_col_err: got %0d pulses, required 0", col_err_seen - ce0);
    end
  endtask

  task automatic test_col_err();
    int lat;
    int ce0;
    fill_random();
    shift_row(63);
    ce0 = col_err_seen;
    push_beats(5'd7, 3'd0, 64, 63);
    latch(5'd7, lat);
    wait_idle("short_row");
    checks++;
    if (col_err_seen !== ce0 + 1) begin
      errors++;
      $display("FAIL short_row_col_err: got %0d pulse cycles, required 1", col_err_seen - ce0);
    end
    fill_random();
    shift_row(65);
    ce0 = col_err_seen;
    push_beats(5'd7, 3'd1, 64, 64);
    latch(5'd7, lat);
    wait_idle("long_row");
    checks++;
    if (col_err_seen !== ce0 + 1) begin
      errors++;
      $display("FAIL long_row_col_err: got %0d pulse cycles, required 1", col_err_seen - ce0);
    end
  endtask

  task automatic test_planes();
    int lat;
    for (int i = 0; i < 9; i++) begin
      fill_random();
      shift_row(64);
      push_beats(5'd3, 3'(i % 8), 64, 64);
      latch(5'd3, lat);
      wait_idle("plane_row3");
    end
    for (int i = 0; i < 2; i++) begin
      fill_random();
      shift_row(64);
      push_beats(5'd4, 3'(i), 64, 64);
      latch(5'd4, lat);
      wait_idle("plane_row4");
    end
  endtask

  task automatic test_backpressure_overrun();
    int lat;
    int ov0;
    int ce0;
    logic [20:0] snap;
    fill_random();
    shift_row(64);
    push_beats(5'd9, 3'd0, 64, 64);
    latch(5'd9, lat);
    wait_col(6'd10, "backpressure");
    i_wr_ready = 1'b0;
    snap = {o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data};
    i_row_sel = 5'd12;
    ov0 = overrun_seen;
    ce0 = col_err_seen;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 5) i_stb = 1'b1;
      if (i == 12) i_stb = 1'b0;
      checks++;
      if ({o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data} !== snap) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got %06h, required %06h", i,
                 {o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data}, snap);
      end
    end
    checks++;
    if (overrun_seen !== ov0 + 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulse cycles, required 1", overrun_seen - ov0);
    end
    checks++;
    if (col_err_seen !== ce0) begin
      errors++;
      $display("FAIL overrun_col_err: got %0d pulses, required 0", col_err_seen - ce0);
    end
    i_wr_ready = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_reset_enable();
    int lat;
    fill_random();
    shift_row(64);
    push_beats(5'd11, 3'd0, 20, 64);
    latch(5'd11, lat);
    wait_col(6'd20, "reset_mid");
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data, o_col_err, o_overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid %0b row %0d col %0d plane %0d data %02h, required all 0",
               o_wr_valid, o_wr_row, o_wr_col, o_wr_plane, o_wr_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick(3);
    wait_idle("reset_mid");

    fill_random();
    shift_row(64);
    push_beats(5'd13, 3'd0, 30, 64);
    latch(5'd13, lat);
    wait_col(6'd30, "disable_mid");
    i_enable = 1'b0;
    i_wr_ready = 1'b0;
    tick(1);
    checks++;
    if (o_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL disable_drop: got valid %0b, required 0", o_wr_valid);
    end
    i_wr_ready = 1'b1;
    shift_row(4);
    latch(5'd14, lat);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL disabled_latch: got valid after %0d clk, required no valid", lat);
    end
    tick(20);
    wait_idle("disabled");
    i_enable = 1'b1;
    tick(3);
    fill_random();
    shift_row(64);
    push_beats(5'd13, 3'd0, 64, 64);
    latch(5'd13, lat);
    wait_idle("reenabled");
  endtask

`ifdef HUB75_RX_OE_MEASURE_EN
  task automatic test_oe_measure();
    int n;
    i_enable = 1'b0;
    i_stb = 1'b1;
    tick(4);
    i_stb = 1'b0;
    tick(5);
    i_oe = 1'b0;
    tick(2048);
    i_oe = 1'b1;
    tick(5);
    i_stb = 1'b1;
    n = 0;
    while (!o_oe_valid && n < 12) begin
      tick(1);
      n++;
    end
    checks++;
    if (!o_oe_valid || o_oe_cycles !== 32'd2048) begin
      errors++;
      $display("FAIL oe_cycles: got valid %0b count %0d, required valid 1 count 2048", o_oe_valid, o_oe_cycles);
    end
    i_stb = 1'b0;
    tick(5);
    i_enable = 1'b1;
    tick(3);
  endtask
`endif

  initial begin
    test_reset();
    test_single_plane();
    test_col_err();
    test_planes();
    test_backpressure_overrun();
    test_reset_enable();
`ifdef HUB75_RX_OE_MEASURE_EN
    test_oe_measure();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- HUB75 receiver/panel model. Samples the six RGB lines, serial clock, STB, OE and row select. Rebuilds each latched bit-plane row and streams it out one column per beat.
- Sits on the far end of the driver outputs. Used for loopback self-check on FPGA and as the scoreboard front-end in simulation.

Parameters:
- hpixel_p, 64, columns per row (shift chain length)
- vpixel_p, 64, display height in pixels
- bpp_p, 8, bit planes per colour channel
- segments_p, 2, display segments (upper/lower halves)
- row_wd_p, $clog2(vpixel_p/segments_p), row address width (local)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  receiver enable
- i_sclk  in  1  HUB75 serial clock (O_CLK)
- i_stb  in  1  latch strobe
- i_oe  in  1  output enable, active-low (low = LEDs on)
- i_row_sel  in  5  {A,B,C,D,E}; row index = {E,D,C,B,A}, A is the LSB
- i_r  in  segments_p  red, bit s = segment s+1
- i_g  in  segments_p  green, bit s = segment s+1
- i_b  in  segments_p  blue, bit s = segment s+1
- o_wr_valid  out  1  column beat valid
- i_wr_ready  in  1  downstream accept
- o_wr_row  out  row_wd_p  row of the beat
- o_wr_col  out  $clog2(hpixel_p)  column of the beat
- o_wr_plane  out  $clog2(bpp_p)  bit-plane index of the beat
- o_wr_data  out  3*segments_p  per segment {R,G,B}; segment 0 in the LSBs
- o_col_err  out  1  1-cycle pulse: latch saw a clock count not equal to hpixel_p
- o_overrun  out  1  1-cycle pulse: STB arrived while draining

Behaviour:
- Input capture
  - All HUB75 inputs go through identical 2-flop synchronisers, so data stays aligned with the synced sclk/stb.
  - Rising edges are detected on synced sclk and stb.
  - Requirement on the upstream driver: sclk high and low phases ≥3 clk; RGB stable ≥3 clk either side of each sclk rise.
- Shift
  - On each sclk rise with i_enable=1, the k-th bit since the last latch (k=0 first) is stored at column k.
  - col_cnt saturates at hpixel_p; clocks beyond that are ignored.
- Latch (stb rise, i_enable=1)
  - If FSM is in DRAIN: pulse o_overrun; hold buffer and FSM unchanged. col_cnt is still cleared and the shift data discarded.
  - Otherwise:
    - Copy the shift buffer to the hold buffer.
    - Capture row from i_row_sel.
    - Plane = number of latches since the last row change, modulo bpp_p; plane resets to 0 when row ≠ previous latched row (first latch after reset also takes plane 0).
    - Pulse o_col_err if col_cnt ≠ hpixel_p.
    - Clear col_cnt. Enter DRAIN the next cycle.
  - sclk rise and stb rise in the same cycle: the shift is applied first, then the latch.
- FSM: IDLE, DRAIN
  - DRAIN: o_wr_valid=1, o_wr_col starts at 0. On valid&ready the column increments.
  - Acceptance of column hpixel_p-1 → IDLE; o_wr_valid low the next cycle.
  - While valid & !ready, all o_wr_* are held stable.
- Output data: o_wr_row, o_wr_plane and o_wr_data are driven from the hold buffer only, never from the shift buffer.
- i_enable low
  - Synchronously clears col_cnt and the plane counter.
  - Forces IDLE and drops o_wr_valid immediately. This is the only permitted valid drop without a handshake.
  - Ignores all edges.
- Reset: all outputs 0, FSM IDLE, counters 0, last-row register 0, buffers 0. Reset mid-DRAIN abandons the beat.
- Latency: stb rise on pin → first o_wr_valid = 4 clk (2 sync + edge detect + register).

Optional Feature:
- Macro HUB75_RX_OE_MEASURE_EN.
- Defined:
  - Adds output o_oe_cycles (32 bits) and o_oe_valid (1-cycle pulse).
  - Counts clk cycles with synced i_oe low between consecutive stb rises.
  - Value is presented at each stb rise, with o_oe_valid, for checking BCM weighting.
  - The counter saturates at all-ones.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Single plane: row=5, 64 sclk with column k = {R2,G2,B2,R1,G1,B1} of k[5:0], stb, ready=1 -> 64 beats, o_wr_row=5, o_wr_plane=0, o_wr_col 0..63, o_wr_data matches k[5:0]; o_col_err stays 0.
- Clock count error: 63 sclk then stb -> o_col_err 1-cycle pulse; 64 beats drained, column 63 = 0. Next latch with 65 sclk -> o_col_err again, extra bit discarded.
- Planes: 8 latches on row 3 then 1 latch on row 4 -> planes 0..7 on row 3, then plane 0 on row 4. A 9th latch on row 3 instead -> plane 0 (wrap).
- Backpressure/overrun: ready=0 for 40 cycles mid-drain -> outputs frozen; stb during DRAIN -> o_overrun pulse, no change to o_wr_row/o_wr_plane; after release the remaining columns drain.
- Reset/enable: assert rst during beat 20 -> o_wr_valid=0 asynchronously, all outputs 0. Drop i_enable mid-drain -> valid low next cycle; stb while disabled -> no beats.
- HUB75_RX_OE_MEASURE_EN: OE low 2048 clk between two stb rises -> o_oe_cycles=2048 with o_oe_valid pulse.
